stack_reg_file: RTL and testbench



---
 rtl/stack_reg_file.sv | 54 +++++
 tb/tb_stack_reg_file.sv | 88 ++++++++
 2 files changed

// File: rtl/stack_reg_file.sv
// stack_reg_file: LIFO operand stack exposing the top two entries, with pop-0/1/2 plus push per edge.
// Define REG_FILE_GUARD_EN to suppress illegal ops and raise a sticky err flag.
module stack_reg_file #(
  parameter int DBITS = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic             we,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout1,
  output logic [DBITS-1:0] dout2,
  output logic             empty,
  output logic             full,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  logic [DBITS-1:0] stk [DEPTH];
  logic [SW-1:0] sp, pops, base, sp_next;
  logic ok;
  always_comb begin
    pops = SW'(en1) + SW'(en1 & en2);
    base = sp - pops;
    sp_next = base + SW'(we);
  end
  assign dout1 = (sp == '0) ? '0 : stk[AW'(sp - SW'(1))];
  assign dout2 = (sp < SW'(2)) ? '0 : stk[AW'(sp - SW'(2))];
  assign empty = sp == '0;
  assign full  = sp == SW'(DEPTH);
`ifdef REG_FILE_GUARD_EN
  logic bad;
  // sp_next may wrap on underflow, but bad is already set by the first term then
  assign bad = (pops > sp) || (sp_next > SW'(DEPTH));
  assign ok  = !bad;
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (bad) err <= 1'b1;
`else
  assign ok  = 1'b1;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else if (ok) begin
      sp <= sp_next;
      if (we) stk[AW'(base)] <= din;
    end
  end
endmodule

// File: tb/tb_stack_reg_file.sv
// tb_stack_reg_file: directed checks of stack_reg_file push/pop behaviour, boundaries and async reset.
module tb_stack_reg_file;
  logic clk = 0, rst = 1, en1 = 0, en2 = 0, we = 0;
  logic [31:0] din = 0, dout1, dout2;
  logic empty, full, err;
  int tests = 0, fails = 0;
`ifdef REG_FILE_GUARD_EN
  localparam bit G = 1;
`else
  localparam bit G = 0;
`endif
  stack_reg_file #(.DBITS(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en1(en1), .en2(en2), .we(we), .din(din),
    .dout1(dout1), .dout2(dout2), .empty(empty), .full(full), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic a, input logic b, input logic w, input logic [31:0] d);
    en1 = a; en2 = b; we = w; din = d;
    @(posedge clk); #1;
    en1 = 0; en2 = 0; we = 0;
  endtask
  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
  endtask
  initial begin
    @(posedge clk); #1;
    chk("rst_dout1", dout1, 0); chk("rst_dout2", dout2, 0);
    chk("rst_empty", {31'b0, empty}, 1); chk("rst_full", {31'b0, full}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, i);
    chk("push4_sp", 32'(dut.sp), 4); chk("push4_d1", dout1, 3);
    chk("push4_d2", dout2, 2); chk("push4_empty", {31'b0, empty}, 0);
    en1 = 1; en2 = 1; we = 1; din = 4; #1;
    chk("bin_pre_d1", dout1, 3); chk("bin_pre_d2", dout2, 2);
    cyc(1, 1, 1, 4);
    chk("bin_sp", 32'(dut.sp), 3); chk("bin_d1", dout1, 4); chk("bin_d2", dout2, 1);
    en1 = 1; #1; chk("pop1_pre_d1", dout1, 4);
    cyc(1, 0, 0, 0);
    chk("pop1_sp", 32'(dut.sp), 2); chk("pop1_d1", dout1, 1); chk("pop1_d2", dout2, 0);
    cyc(0, 1, 0, 0);
    chk("en2only_sp", 32'(dut.sp), 2);
    en1 = 1; en2 = 1; #1; chk("pop2_pre_d1", dout1, 1); chk("pop2_pre_d2", dout2, 0);
    cyc(1, 1, 0, 0);
    chk("pop2_empty", {31'b0, empty}, 1); chk("pop2_d1", dout1, 0); chk("pop2_d2", dout2, 0);
    chk("legal_err", {31'b0, err}, 0);
    cyc(1, 0, 0, 0);
    chk("underflow_err", {31'b0, err}, {31'b0, G});
    if (G) begin
      chk("underflow_sp", 32'(dut.sp), 0);
      cyc(0, 0, 1, 9);
      chk("err_sticky", {31'b0, err}, 1);
      cyc(1, 1, 0, 0);
      chk("pop2_sp1_sp", 32'(dut.sp), 1); chk("pop2_sp1_d1", dout1, 9);
    end
    do_reset();
    chk("reset_clears_err", {31'b0, err}, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 100 + i);
    chk("fill_full", {31'b0, full}, 1); chk("fill_err", {31'b0, err}, 0);
    chk("fill_d1", dout1, 115);
    cyc(1, 0, 1, 200);
    chk("full_repl_full", {31'b0, full}, 1); chk("full_repl_d1", dout1, 200);
    chk("full_repl_d2", dout2, 114); chk("full_repl_err", {31'b0, err}, 0);
    cyc(0, 0, 1, 116);
    chk("ovf_err", {31'b0, err}, {31'b0, G});
    chk("ovf_full", {31'b0, full}, {31'b0, G});
    chk("ovf_d1", dout1, G ? 200 : 116);
    do_reset();
    cyc(0, 0, 1, 7); cyc(0, 0, 1, 8);
    en1 = 0; we = 1; din = 55;
    #2 rst = 1; #1;
    chk("async_d1", dout1, 0); chk("async_d2", dout2, 0);
    chk("async_empty", {31'b0, empty}, 1); chk("async_full", {31'b0, full}, 0);
    @(posedge clk); #1;
    we = 0; rst = 0;
    @(posedge clk); #1;
    chk("async_lost", 32'(dut.sp), 0); chk("async_lost_d1", dout1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
